tactile_frame_packer: RTL and testbench
=======================================

// Module: tactile_frame_packer
// PURPOSE
//  Upstream stage of the UART upload path. Takes one tactile frame of N_CH ADC samples via valid/ready and
//  serialises it as bytes into the upload FIFO (wFIFO_idata/wFIFO_wrreq/wFIFO_full):
//  header, frame counter, samples, optional checksum. Then pulses uart_send and waits for uart_send_done
//  before accepting the next frame.
// PARAMETERS
//  N_CH      16     samples per frame (1..255)
//  SAMPLE_W  12     sample width in bits (9..16); each sample is sent as 2 bytes, MSB byte first
//  HDR0      8'hAA  first sync byte
//  HDR1      8'h55  second sync byte
// PORTS
//  clk_50m         in   1         system clock, 50 MHz
//  rst             in   1         asynchronous, active-high reset
//  frame_start     in   1         1-cycle pulse: begin a frame (ignored unless IDLE)
//  smp_data        in   SAMPLE_W  sample value
//  smp_valid       in   1         smp_data valid
//  smp_ready       out  1         sample accepted on smp_valid&&smp_ready
//  wFIFO_idata     out  8         byte to upload FIFO
//  wFIFO_wrreq     out  1         write strobe, same cycle as wFIFO_idata
//  wFIFO_full      in   1         upload FIFO full
//  uart_send       out  1         1-cycle pulse: start transmission of FIFO contents
//  uart_rdy        in   1         uploader idle
//  uart_send_done  in   1         uploader finished (FIFO drained)
//  busy            out  1         high from accepted frame_start until uart_send_done
//  overrun         out  1         sticky: frame_start seen while busy; cleared only by rst
// BEHAVIOUR
//  - Reset: state IDLE; smp_ready, wFIFO_wrreq, uart_send, busy, overrun = 0; wFIFO_idata = 0;
//    frame counter = 0. Reset does not flush the FIFO; a mid-frame reset leaves a partial frame,
//    and the host resyncs on HDR0/HDR1.
//  - FSM: IDLE -> HDR0 -> HDR1 -> CNT -> {SMP_HI <-> SMP_LO} x N_CH -> [CKSUM] -> SEND -> WAIT_DONE -> IDLE.
//  - Every byte-emitting state (HDR0, HDR1, CNT, SMP_LO, CKSUM) writes exactly one byte:
//    wrreq=1 only in a cycle where wFIFO_full=0, then advances. If full, hold with wrreq=0.
//  - SMP_HI: smp_ready = !wFIFO_full. On accept, write {zero-pad, smp_data[SAMPLE_W-1:8]} and
//    latch smp_data[7:0]. SMP_LO writes the latched byte.
//    Sample index counts 0..N_CH-1; after the Nth SMP_LO go to CKSUM or SEND.
//  - smp_ready is 0 in every state except SMP_HI; samples offered outside a frame are not consumed.
//  - CNT byte = frame counter (8 bit, wraps 255->0); counter increments on entry to SEND.
//  - SEND: wait for uart_rdy=1, then pulse uart_send for exactly 1 cycle and go to WAIT_DONE.
//    WAIT_DONE: on uart_send_done=1 go to IDLE. busy drops the cycle after.
//  - Throughput: 1 byte/cycle when not full; frame write time = 3+2*N_CH(+1) cycles minimum.
//  - Frame bytes (3+2*N_CH+1 = 36 by default) must not exceed upload FIFO depth: the whole frame is
//    written before uart_send.
//  - frame_start while busy: ignored, overrun<=1. frame_start and uart_send_done in the same cycle
//    (WAIT_DONE): done wins, and start is ignored and flagged.
// CONFIGURATION
//  FRAME_CKSUM_EN defined: CKSUM state appends 1 byte = XOR of the CNT byte and all sample bytes
//    (headers excluded). The accumulator clears on frame_start.
//  Undefined: no CKSUM state; frame = 3+2*N_CH bytes; SMP_LO (last) -> SEND directly.
// STRUCTURE
//  - Package tactile_frame_pkg: FSM state typedef; HDR defaults; function frame_bytes(N_CH) used for
//    the FIFO-depth check.
//  - No sub-module; byte mux, sample index counter and checksum accumulator are inline.
// TESTING
//  - Reset mid-SMP_LO (rst=1 for 2 cycles) -> all outputs 0, IDLE; next frame_start gives
//    HDR0=8'hAA as the first write.
//  - N_CH=16, FIFO never full, samples 12'h000..12'h00F -> writes AA 55 00, then 00 00, 00 01 .. 00 0F;
//    with FRAME_CKSUM_EN the last byte is 8'h00. uart_send pulses once; busy is held until done.
//  - Sample 12'hABC -> bytes 0x0A then 0xBC. wFIFO_full forced high 5 cycles during SMP_LO ->
//    no wrreq and no smp_ready those cycles; the byte appears once after release, with no duplicates
//    or drops.
//  - 256 frames -> CNT bytes run 0x00..0xFF, then the 257th frame carries 0x00.
//  - frame_start pulsed in HDR1 and in WAIT_DONE -> ignored, overrun=1 and sticky; frame content unchanged.
//  - uart_rdy held 0 for 20 cycles in SEND -> uart_send stays 0, then exactly one 1-cycle pulse after
//    uart_rdy rises.

Source files
------------

// File: rtl/tactile_frame_packer_pkg.sv
// tactile_frame_pkg: FSM states, sync-byte defaults and frame sizing for the tactile upload packer.
// FRAME_CKSUM_EN adds the trailing XOR checksum byte to every frame.
package tactile_frame_pkg;
  typedef enum logic [3:0] {
    ST_IDLE, ST_HDR0, ST_HDR1, ST_CNT, ST_SMP_HI, ST_SMP_LO, ST_CKSUM, ST_SEND, ST_WAIT_DONE
  } st_e;
  localparam logic [7:0] HDR0_DEF = 8'hAA;
  localparam logic [7:0] HDR1_DEF = 8'h55;
`ifdef FRAME_CKSUM_EN
  localparam bit CKSUM_EN = 1'b1;
  localparam st_e AFTER_SMP = ST_CKSUM;
`else
  localparam bit CKSUM_EN = 1'b0;
  localparam st_e AFTER_SMP = ST_SEND;
`endif
  function automatic int frame_bytes(input int n_ch);
    return 3 + 2 * n_ch + (CKSUM_EN ? 1 : 0);
  endfunction
endpackage

// File: rtl/tactile_frame_packer_if.sv
// tactile_frame_packer_if: sample, upload-FIFO and uploader handshake signals of the frame packer.
interface tactile_frame_packer_if #(parameter int SAMPLE_W = 12);
  logic                frame_start;
  logic [SAMPLE_W-1:0] smp_data;
  logic                smp_valid;
  logic                smp_ready;
  logic [7:0]          wFIFO_idata;
  logic                wFIFO_wrreq;
  logic                wFIFO_full;
  logic                uart_send;
  logic                uart_rdy;
  logic                uart_send_done;
  logic                busy;
  logic                overrun;
  modport master (
    input  frame_start, smp_data, smp_valid, wFIFO_full, uart_rdy, uart_send_done,
    output smp_ready, wFIFO_idata, wFIFO_wrreq, uart_send, busy, overrun
  );
  modport slave (
    output frame_start, smp_data, smp_valid, wFIFO_full, uart_rdy, uart_send_done,
    input  smp_ready, wFIFO_idata, wFIFO_wrreq, uart_send, busy, overrun
  );
endinterface

// File: rtl/tactile_frame_packer.sv
// tactile_frame_packer: serialises one frame of ADC samples into the upload FIFO, then triggers the UART.
// Define FRAME_CKSUM_EN to append the XOR checksum byte (CNT byte and all sample bytes).
module tactile_frame_packer import tactile_frame_pkg::*; #(
  parameter int         N_CH       = 16,
  parameter int         SAMPLE_W   = 12,
  parameter logic [7:0] HDR0       = HDR0_DEF,
  parameter logic [7:0] HDR1       = HDR1_DEF,
  parameter int         FIFO_DEPTH = 64
) (
  input logic                   clk_50m,
  input logic                   rst,
  tactile_frame_packer_if.master bus
);
  st_e        state;
  logic [7:0] frame_cnt, idx, lo_byte, cksum, hi_byte, wr_data;
  logic       wr_en, last_smp, uart_send_r, busy_r, overrun_r;
  // The whole frame is queued before uart_send, so it must fit in the FIFO.
  if (N_CH < 1 || N_CH > 255 || SAMPLE_W < 9 || SAMPLE_W > 16 || frame_bytes(N_CH) > FIFO_DEPTH) begin : g_bad_cfg
    $error("tactile_frame_packer: unsupported N_CH/SAMPLE_W/FIFO_DEPTH");
  end
  assign hi_byte  = 8'(bus.smp_data >> 8);
  assign last_smp = idx == 8'(N_CH - 1);
  assign wr_en    = !bus.wFIFO_full &&
                    (state inside {ST_HDR0, ST_HDR1, ST_CNT, ST_SMP_LO, ST_CKSUM} ||
                     (state == ST_SMP_HI && bus.smp_valid));
  assign wr_data  = state == ST_HDR0   ? HDR0 :
                    state == ST_HDR1   ? HDR1 :
                    state == ST_CNT    ? frame_cnt :
                    state == ST_SMP_HI ? hi_byte :
                    state == ST_SMP_LO ? lo_byte :
                    state == ST_CKSUM  ? cksum : 8'h00;
  assign bus.smp_ready   = state == ST_SMP_HI && !bus.wFIFO_full;
  assign bus.wFIFO_wrreq = wr_en;
  assign bus.wFIFO_idata = wr_data;
  assign bus.uart_send   = uart_send_r;
  assign bus.busy        = busy_r;
  assign bus.overrun     = overrun_r;
`ifdef FRAME_CKSUM_EN
  always_ff @(posedge clk_50m or posedge rst)
    if (rst) cksum <= '0;
    else if (state == ST_IDLE && bus.frame_start) cksum <= '0;
    else if (wr_en && state inside {ST_CNT, ST_SMP_HI, ST_SMP_LO}) cksum <= cksum ^ wr_data;
`else
  assign cksum = 8'h00;
`endif
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      frame_cnt   <= '0;
      idx         <= '0;
      lo_byte     <= '0;
      uart_send_r <= 1'b0;
      busy_r      <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      uart_send_r <= 1'b0;
      if (bus.frame_start && state != ST_IDLE) overrun_r <= 1'b1;
      case (state)
        ST_IDLE: if (bus.frame_start) begin
          state  <= ST_HDR0;
          busy_r <= 1'b1;
          idx    <= '0;
        end
        ST_HDR0: if (wr_en) state <= ST_HDR1;
        ST_HDR1: if (wr_en) state <= ST_CNT;
        ST_CNT:  if (wr_en) state <= ST_SMP_HI;
        ST_SMP_HI: if (wr_en) begin
          lo_byte <= bus.smp_data[7:0];
          state   <= ST_SMP_LO;
        end
        ST_SMP_LO: if (wr_en) begin
          idx   <= idx + 8'd1;
          state <= last_smp ? AFTER_SMP : ST_SMP_HI;
          if (last_smp && AFTER_SMP == ST_SEND) frame_cnt <= frame_cnt + 8'd1;
        end
        ST_CKSUM: if (wr_en) begin
          state     <= ST_SEND;
          frame_cnt <= frame_cnt + 8'd1;
        end
        ST_SEND: if (bus.uart_rdy) begin
          uart_send_r <= 1'b1;
          state       <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: if (bus.uart_send_done) begin
          state  <= ST_IDLE;
          busy_r <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tactile_frame_packer.sv
// tb_tactile_frame_packer: directed checks of framing, flow control, counter wrap, overrun and reset.
module tb_tactile_frame_packer;
  import tactile_frame_pkg::*;
  localparam int N_CH = 16;
  localparam int FB   = frame_bytes(N_CH);
  logic       clk_50m = 1'b0;
  logic       rst     = 1'b1;
  logic [7:0]  cap[$];
  logic [11:0] sq[$];
  int sends, checks, errors;
  tactile_frame_packer_if #(.SAMPLE_W(12)) bus ();
  tactile_frame_packer #(.N_CH(N_CH), .SAMPLE_W(12)) dut (.clk_50m(clk_50m), .rst(rst), .bus(bus));
  initial forever #10 clk_50m = ~clk_50m;
  always @(negedge clk_50m) begin
    if (bus.wFIFO_wrreq) cap.push_back(bus.wFIFO_idata);
    if (bus.uart_send) sends++;
  end
  initial begin
    bit acc;
    bus.smp_valid = 1'b0;
    bus.smp_data  = '0;
    forever begin
      @(negedge clk_50m);
      acc = bus.smp_valid && bus.smp_ready;
      @(posedge clk_50m);
      #1;
      if (acc && sq.size() > 0) void'(sq.pop_front());
      bus.smp_valid = sq.size() > 0;
      bus.smp_data  = sq.size() > 0 ? sq[0] : 12'h000;
    end
  end
  task automatic step();
    @(posedge clk_50m);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic start_frame();
    bus.frame_start = 1'b1;
    step();
    bus.frame_start = 1'b0;
  endtask
  task automatic wait_cap(input int n, input string tag);
    int k = 0;
    while (cap.size() < n && k < 500) begin step(); k++; end
    chk(tag, cap.size(), n);
  endtask
  task automatic finish_frame();
    int k = 0;
    while (sends == 0 && k < 300) begin step(); k++; end
    chk("send_seen", sends, 1);
    chk("busy_hold", bus.busy, 1);
    repeat (2) step();
    chk("busy_wait", bus.busy, 1);
    bus.uart_send_done = 1'b1;
    step();
    bus.uart_send_done = 1'b0;
    chk("busy_drop", bus.busy, 0);
  endtask
  task automatic check_bytes(input string tag, input logic [7:0] cnt, input logic [11:0] s[$]);
    logic [7:0] exp[$];
    logic [7:0] cks;
    exp = '{8'hAA, 8'h55, cnt};
    cks = cnt;
    foreach (s[i]) begin
      exp.push_back({4'h0, s[i][11:8]});
      exp.push_back(s[i][7:0]);
      cks = cks ^ {4'h0, s[i][11:8]} ^ s[i][7:0];
    end
    if (CKSUM_EN) exp.push_back(cks);
    chk({tag, "_len"}, cap.size(), exp.size());
    foreach (exp[i]) chk($sformatf("%s_b%0d", tag, i), cap[i], exp[i]);
  endtask
  initial begin
    logic [11:0] s[$];
    bus.frame_start = 1'b0; bus.wFIFO_full = 1'b0; bus.uart_rdy = 1'b1; bus.uart_send_done = 1'b0;
    checks = 0; errors = 0; sends = 0;
    repeat (3) step();
    rst = 1'b0;
    step();
    @(negedge clk_50m);
    chk("rst_ready", bus.smp_ready, 0);
    chk("rst_wrreq", bus.wFIFO_wrreq, 0);
    chk("rst_idata", bus.wFIFO_idata, 0);
    chk("rst_send", bus.uart_send, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_overrun", bus.overrun, 0);
    // samples offered while idle must stay queued
    s = {};
    for (int i = 0; i < N_CH; i++) s.push_back(12'(i));
    sq = s;
    repeat (3) step();
    @(negedge clk_50m);
    chk("idle_valid", bus.smp_valid, 1);
    chk("idle_ready", bus.smp_ready, 0);
    chk("idle_keep", sq.size(), N_CH);
    step();
    cap.delete(); sends = 0;
    start_frame();
    chk("f0_busy", bus.busy, 1);
    finish_frame();
    check_bytes("f0", 8'h00, s);
    if (CKSUM_EN) chk("f0_cksum", cap[FB-1], 8'h00);
    chk("f0_sends", sends, 1);
    // 12'hABC with FIFO full for 5 cycles in SMP_LO
    s = {12'hABC};
    for (int i = 1; i < N_CH; i++) s.push_back(12'h000);
    sq = s; cap.delete(); sends = 0;
    start_frame();
    wait_cap(4, "f1_hi_written");
    bus.wFIFO_full = 1'b1;
    repeat (5) begin
      @(negedge clk_50m);
      chk("full_wrreq", bus.wFIFO_wrreq, 0);
      chk("full_ready", bus.smp_ready, 0);
      step();
    end
    bus.wFIFO_full = 1'b0;
    finish_frame();
    chk("abc_hi", cap[3], 8'h0A);
    chk("abc_lo", cap[4], 8'hBC);
    check_bytes("f1", 8'h01, s);
    // frame_start during HDR1 and together with done in WAIT_DONE
    chk("ovr_before", bus.overrun, 0);
    s = {};
    for (int i = 0; i < N_CH; i++) s.push_back(12'(12'h3C0 + i * 7));
    sq = s; cap.delete(); sends = 0;
    start_frame();
    wait_cap(1, "f2_hdr0");
    start_frame();
    chk("ovr_hdr1", bus.overrun, 1);
    begin
      int k = 0;
      while (sends == 0 && k < 300) begin step(); k++; end
    end
    chk("f2_send", sends, 1);
    bus.frame_start = 1'b1; bus.uart_send_done = 1'b1;
    step();
    bus.frame_start = 1'b0; bus.uart_send_done = 1'b0;
    chk("f2_done_wins", bus.busy, 0);
    repeat (3) step();
    chk("f2_no_restart", bus.busy, 0);
    chk("ovr_sticky", bus.overrun, 1);
    check_bytes("f2", 8'h02, s);
    // uploader not ready for 20 cycles
    bus.uart_rdy = 1'b0;
    sq = s; cap.delete(); sends = 0;
    start_frame();
    wait_cap(FB, "f3_all_bytes");
    repeat (20) step();
    chk("rdy_low_send", sends, 0);
    bus.uart_rdy = 1'b1;
    finish_frame();
    repeat (3) step();
    chk("rdy_one_pulse", sends, 1);
    check_bytes("f3", 8'h03, s);
    // reset in the middle of SMP_LO
    sq = s; cap.delete(); sends = 0;
    start_frame();
    wait_cap(4, "f4_hi_written");
    rst = 1'b1;
    @(negedge clk_50m);
    chk("mrst_ready", bus.smp_ready, 0);
    chk("mrst_wrreq", bus.wFIFO_wrreq, 0);
    chk("mrst_idata", bus.wFIFO_idata, 0);
    chk("mrst_send", bus.uart_send, 0);
    chk("mrst_busy", bus.busy, 0);
    chk("mrst_overrun", bus.overrun, 0);
    step();
    step();
    rst = 1'b0;
    sq.delete(); cap.delete();
    step();
    sq = s; sends = 0;
    start_frame();
    finish_frame();
    chk("mrst_first", cap[0], 8'hAA);
    check_bytes("f5", 8'h00, s);
    // counter wrap: frames 1..256 after reset carry 0x01..0xFF then 0x00
    for (int f = 1; f <= 256; f++) begin
      sq = s; cap.delete(); sends = 0;
      start_frame();
      finish_frame();
      chk($sformatf("cnt%0d", f), cap[2], 32'(f % 256));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
